// File: rtl/axis_frame_gen.sv
// AXI4-Stream test-frame generator: ramp, constant or LFSR payload in fixed-length frames.
// Optional per-frame XOR checksum outputs are enabled with `define AXIS_FRAME_GEN_CHECKSUM_EN.
module axis_frame_gen #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_NET_CELL_COUNT       = 2,
  parameter int C_FRAME_GAP            = 0
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_aresetn,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic [15:0]                           frame_count,
  input  logic [1:0]                            mode,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]     seed,
  output logic                                  m00_axis_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  input  logic                                  m00_axis_tready,
  output logic                                  busy,
  output logic                                  done,
  output logic [15:0]                           frames_sent
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
  ,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     checksum,
  output logic                                  checksum_valid
`endif
);

  localparam int              W         = C_M00_AXIS_TDATA_WIDTH;
  localparam int              L         = 9 + (C_NET_CELL_COUNT - 1) * 3;
  localparam int              IW        = $clog2(L);
  localparam logic [IW-1:0]   PRE_LAST  = IW'(L - 2);
  localparam logic [7:0]      GAP_LOAD  = (C_FRAME_GAP > 0) ? 8'(C_FRAME_GAP - 1) : 8'd0;
  localparam logic [31:0]     LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {M_RAMP = 2'b00, M_CONST = 2'b01, M_LFSR = 2'b10, M_RSVD = 2'b11} mode_t;

  state_t          r_state;
  mode_t           r_mode;
  logic [W-1:0]    r_seed;
  logic [15:0]     r_frame_count;
  logic [15:0]     r_frames_sent;
  logic            r_stop_seen;
  logic [IW-1:0]   r_word_idx;
  logic [7:0]      r_gap_cnt;
  logic [31:0]     r_lfsr;
  logic [W-1:0]    r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic            r_busy;
  logic            r_done;

  logic            w_handshake;
  logic [15:0]     w_frames_inc;
  logic            w_run_end;
  logic [31:0]     w_lfsr_next;
  logic [31:0]     w_lfsr_first;
  logic [W-1:0]    w_next_data;

  assign w_handshake  = r_tvalid & m00_axis_tready;
  assign w_frames_inc = r_frames_sent + 16'd1;
  // A stop arriving in the same cycle as the tlast handshake still ends the run there.
  assign w_run_end    = ((r_frame_count != 16'd0) && (w_frames_inc == r_frame_count))
                        || r_stop_seen || stop;
  assign w_lfsr_next  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_MASK : 32'd0);
  assign w_lfsr_first = (seed[31:0] == 32'd0) ? 32'd1 : seed[31:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    w_next_data = r_tdata + W'(1);
    case (r_mode)
      M_CONST: w_next_data = r_seed;
      M_LFSR:  w_next_data = W'(w_lfsr_next);
      default: w_next_data = r_tdata + W'(1);
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_state       <= S_IDLE;
      r_mode        <= M_RAMP;
      r_seed        <= '0;
      r_frame_count <= '0;
      r_frames_sent <= '0;
      r_stop_seen   <= 1'b0;
      r_word_idx    <= '0;
      r_gap_cnt     <= '0;
      r_lfsr        <= '0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_SEND;
            r_mode        <= mode_t'(mode);
            r_seed        <= seed;
            r_frame_count <= frame_count;
            r_frames_sent <= '0;
            r_stop_seen   <= stop;
            r_lfsr        <= w_lfsr_first;
            r_tdata       <= (mode_t'(mode) == M_LFSR) ? W'(w_lfsr_first) : seed;
            r_word_idx    <= '0;
            r_tvalid      <= 1'b1;
            r_tlast       <= 1'b0;
            r_busy        <= 1'b1;
          end
        end

        S_SEND: begin
          if (stop) r_stop_seen <= 1'b1;
          if (w_handshake) begin
            r_tdata <= w_next_data;
            r_lfsr  <= w_lfsr_next;
            if (r_tlast) begin
              r_frames_sent <= w_frames_inc;
              r_word_idx    <= '0;
              r_tlast       <= 1'b0;
              if (w_run_end) begin
                r_state     <= S_DONE;
                r_tvalid    <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_stop_seen <= 1'b0;
              end else if (C_FRAME_GAP != 0) begin
                r_state   <= S_GAP;
                r_tvalid  <= 1'b0;
                r_gap_cnt <= GAP_LOAD;
              end
            end else begin
              r_word_idx <= r_word_idx + IW'(1);
              r_tlast    <= (r_word_idx == PRE_LAST);
            end
          end
        end

        S_GAP: begin
          if (stop) r_stop_seen <= 1'b1;
          if (r_gap_cnt == 8'd0) begin
            r_state  <= S_SEND;
            r_tvalid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tstrb  = {(W/8){r_tvalid}};
  assign m00_axis_tlast  = r_tlast;
  assign busy            = r_busy;
  assign done            = r_done;
  assign frames_sent     = r_frames_sent;

`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
  logic [W-1:0] r_csum_acc;
  logic [W-1:0] r_checksum;
  logic         r_checksum_valid;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_csum_acc       <= '0;
      r_checksum       <= '0;
      r_checksum_valid <= 1'b0;
    end else begin
      r_checksum_valid <= 1'b0;
      if ((r_state == S_IDLE) && start) begin
        r_csum_acc <= '0;
      end else if (w_handshake) begin
        if (r_tlast) begin
          r_checksum       <= r_csum_acc ^ r_tdata;
          r_checksum_valid <= 1'b1;
          r_csum_acc       <= '0;
        end else begin
          r_csum_acc <= r_csum_acc ^ r_tdata;
        end
      end
    end
  end

  assign checksum       = r_checksum;
  assign checksum_valid = r_checksum_valid;
`endif

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: a per-word stream model checked every cycle,
// plus literal expectations for the named scenarios (frame length 12, frame gap 2).
module tb_axis_frame_gen;

  localparam int W   = 32;
  localparam int N   = 2;
  localparam int GAP = 2;
  localparam int L   = 9 + (N - 1) * 3;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           stop;
  logic [15:0]    frame_count;
  logic [1:0]     mode;
  logic [W-1:0]   seed;
  logic           tvalid;
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tstrb;
  logic           tlast;
  logic           tready;
  logic           busy;
  logic           done;
  logic [15:0]    frames_sent;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
  logic [W-1:0]   checksum;
  logic           checksum_valid;
`endif

  axis_frame_gen #(
    .C_M00_AXIS_TDATA_WIDTH(W),
    .C_NET_CELL_COUNT      (N),
    .C_FRAME_GAP           (GAP)
  ) dut (
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
    .checksum        (checksum),
    .checksum_valid  (checksum_valid),
`endif
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst_n),
    .start           (start),
    .stop            (stop),
    .frame_count     (frame_count),
    .mode            (mode),
    .seed            (seed),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tlast  (tlast),
    .m00_axis_tready (tready),
    .busy            (busy),
    .done            (done),
    .frames_sent     (frames_sent)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  // tready: held high, or toggled every cycle when tready_toggle is set.
  logic tready_toggle = 1'b0;
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = tready_toggle ? ~tready : 1'b1;
    end
  end

  // Expected word k of a run, straight from the payload rules.
  function automatic logic [W-1:0] model_word(input logic [1:0] md, input logic [W-1:0] sd,
                                               input int k);
    logic [31:0] x;
    case (md)
      2'b01: return sd;
      2'b10: begin
        x = (sd[31:0] == 32'd0) ? 32'd1 : sd[31:0];
        for (int i = 0; i < k; i++) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return W'(x);
      end
      default: return sd + W'(k);
    endcase
  endfunction

  // Stream model: run state as plain counters, compared every cycle.
  logic         m_active = 1'b0;
  logic         m_done = 1'b0;
  logic         m_stop = 1'b0;
  logic [1:0]   m_mode = 2'b00;
  logic [W-1:0] m_seed = '0;
  logic [15:0]  m_fc = '0;
  logic [15:0]  m_frames = '0;
  int           m_k = 0;
  int           m_gap_left = 0;
  logic [W-1:0] m_acc = '0;
  logic [W-1:0] m_csum_exp = '0;
  logic         m_csum_pulse = 1'b0;
  logic         exp_valid;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_tvalid", tvalid, 0);
      check("rst_tlast", tlast, 0);
      check("rst_tdata", tdata, 0);
      check("rst_tstrb", tstrb, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_frames_sent", frames_sent, 0);
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      check("rst_checksum", checksum, 0);
      check("rst_checksum_valid", checksum_valid, 0);
`endif
      m_active = 0; m_done = 0; m_stop = 0; m_frames = 0; m_k = 0;
      m_gap_left = 0; m_acc = 0; m_csum_pulse = 0;
    end else begin
      exp_valid = m_active && (m_gap_left == 0);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("tvalid", tvalid, exp_valid);
      check("tstrb", tstrb, {(W/8){exp_valid}});
      check("frames_sent", frames_sent, m_frames);
      if (exp_valid) begin
        check("tdata", tdata, model_word(m_mode, m_seed, m_k));
        check("tlast", tlast, (m_k % L) == L - 1);
      end
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      check("checksum_valid", checksum_valid, m_csum_pulse);
      if (m_csum_pulse) check("checksum", checksum, m_csum_exp);
`endif
      m_csum_pulse = 0;
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_mode = mode; m_seed = seed; m_fc = frame_count;
          m_frames = 0; m_k = 0; m_stop = stop; m_gap_left = 0; m_acc = 0;
        end
      end else begin
        if (stop) m_stop = 1;
        if (m_gap_left > 0) begin
          m_gap_left--;
        end else if (tready) begin
          m_acc ^= model_word(m_mode, m_seed, m_k);
          if ((m_k % L) == L - 1) begin
            m_frames++;
            m_csum_exp = m_acc; m_acc = 0; m_csum_pulse = 1;
            if (((m_fc != 0) && (m_frames == m_fc)) || m_stop) begin
              m_active = 0; m_done = 1;
            end else begin
              m_gap_left = GAP;
            end
          end
          m_k++;
        end
      end
    end
  end

  // Raw handshake log used by the literal expectations.
  int           hs_cnt = 0;
  int           tl_cnt = 0;
  int           run_base = 0;
  int           tl_base = 0;
  logic [W-1:0] hs_data [64];

  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      if (hs_cnt - run_base < 64) hs_data[hs_cnt - run_base] = tdata;
      hs_cnt++;
      if (tlast) tl_cnt++;
    end
  end

  task automatic do_start(input logic [1:0] md, input logic [W-1:0] sd,
                          input logic [15:0] fc, input logic with_stop);
    @(posedge clk);
    #1;
    run_base = hs_cnt;
    tl_base = tl_cnt;
    mode = md; seed = sd; frame_count = fc;
    start = 1'b1; stop = with_stop;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_done(input int max, output int cycles);
    cycles = 0;
    while (cycles < max) begin
      @(negedge clk);
      #1;
      cycles++;
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  task automatic wait_hs(input int n, input int max);
    int c = 0;
    while ((hs_cnt - run_base < n) && (c < max)) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("handshake_reached", hs_cnt - run_base >= n, 1);
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    frame_count = '0; mode = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ramp, seed 0, one frame, tready always high.
    do_start(2'b00, '0, 16'd1, 1'b0);
    wait_done(100, cyc);
    check("t1_cycles_to_done", cyc, 13);
    check("t1_words", hs_cnt - run_base, 12);
    check("t1_tlasts", tl_cnt - tl_base, 1);
    check("t1_word0", hs_data[0], 0);
    check("t1_word11", hs_data[11], 11);
    check("t1_frames_sent", frames_sent, 1);

    // Same with tready toggling.
    tready_toggle = 1'b1;
    do_start(2'b00, '0, 16'd1, 1'b0);
    wait_done(100, cyc);
    check("t2_words", hs_cnt - run_base, 12);
    check("t2_tlasts", tl_cnt - tl_base, 1);
    check("t2_word5", hs_data[5], 5);
    check("t2_word11", hs_data[11], 11);
    tready_toggle = 1'b0;

    // Constant, three frames with gaps; a start mid-run must be ignored.
    do_start(2'b01, 32'hA5A5_A5A5, 16'd3, 1'b0);
    wait_hs(14, 100);
    @(posedge clk); #1;
    seed = 32'h1111_1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200, cyc);
    check("t3_words", hs_cnt - run_base, 36);
    check("t3_tlasts", tl_cnt - tl_base, 3);
    check("t3_word35", hs_data[35], 32'hA5A5_A5A5);
    check("t3_frames_sent", frames_sent, 3);

    // LFSR from seed 0.
    do_start(2'b10, '0, 16'd1, 1'b0);
    wait_done(100, cyc);
    check("t4_word0", hs_data[0], 32'h0000_0001);
    check("t4_word1", hs_data[1], 32'h8020_0003);
    check("t4_word2", hs_data[2], 32'hC030_0002);

    // Continuous run ended by a stop pulse inside frame 2.
    do_start(2'b00, 32'd100, 16'd0, 1'b0);
    wait_hs(L + 5, 200);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done(200, cyc);
    check("t5_frames_sent", frames_sent, 2);
    check("t5_tlasts", tl_cnt - tl_base, 2);
    check("t5_words", hs_cnt - run_base, 24);

    // Stop in IDLE is ignored; reserved mode behaves as ramp, wrapping.
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    do_start(2'b11, 32'hFFFF_FFF8, 16'd2, 1'b0);
    wait_done(200, cyc);
    check("t6_frames_sent", frames_sent, 2);
    check("t6_word8", hs_data[8], 0);
    check("t6_word23", hs_data[23], 32'h0000_000F);

    // Start and stop together: exactly one frame.
    do_start(2'b01, 32'h1234_5678, 16'd0, 1'b1);
    wait_done(200, cyc);
    check("t7_frames_sent", frames_sent, 1);
    check("t7_words", hs_cnt - run_base, 12);

    // Reset mid-frame drops tvalid at once; a fresh run restarts at word 0.
    do_start(2'b00, 32'd1, 16'd1, 1'b0);
    wait_hs(6, 100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t8_async_tvalid", tvalid, 0);
    check("t8_async_tlast", tlast, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(2'b00, 32'd1, 16'd1, 1'b0);
    wait_done(100, cyc);
    check("t8_word0", hs_data[0], 1);
    check("t8_words", hs_cnt - run_base, 12);
    check("t8_tlasts", tl_cnt - tl_base, 1);
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
    check("t8_checksum", checksum, 32'h0000_000C);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
